cuboid_prcr_arb: RTL

- Round-robin arbiter and sequencer that shares one cuboid_prcr datapath instance among NUM_REQ requesters.
- Accepts at most one request per cycle and drives registered operands into the datapath.
- Tracks the owning requester of each in-flight operation through the datapath latency, then steers area/volume into a per-requester response slot held under a valid/ready handshake.
- Sits between the requester fabric and the cuboid_prcr instance; the datapath itself is unchanged.

---
 rtl/cuboid_prcr_arb.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/cuboid_prcr_arb.sv
// Round-robin front end that shares one cuboid_prcr datapath among NUM_REQ requesters.
// Each in-flight operation carries its owner tag down a pipeline matched to the datapath latency.
module cuboid_prcr_arb #(
  parameter int NUM_REQ = 4,
  parameter int DP_LAT  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [16*NUM_REQ-1:0]   req_length,
  input  logic [16*NUM_REQ-1:0]   req_width,
  input  logic [16*NUM_REQ-1:0]   req_height,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [32*NUM_REQ-1:0]   rsp_area,
  output logic [32*NUM_REQ-1:0]   rsp_volume,
  output logic [15:0]             dp_length,
  output logic [15:0]             dp_width,
  output logic [15:0]             dp_height,
  output logic                    dp_in_valid,
  input  logic                    dp_out_valid,
  input  logic [31:0]             dp_area,
  input  logic [31:0]             dp_volume,
  output logic                    busy,
  output logic                    proto_err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW    = IDX_W + 1;
  localparam int TAG_N = DP_LAT + 1;

  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]     outstanding_q, outstanding_d;
  logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic [32*NUM_REQ-1:0]  rsp_area_q, rsp_area_d;
  logic [32*NUM_REQ-1:0]  rsp_volume_q, rsp_volume_d;
  logic [15:0]            dp_length_q, dp_length_d;
  logic [15:0]            dp_width_q, dp_width_d;
  logic [15:0]            dp_height_q, dp_height_d;
  logic                   dp_in_valid_q, dp_in_valid_d;
  logic                   proto_err_q, proto_err_d;
  logic [TAG_N-1:0]       tag_vld_q, tag_vld_d;
  logic [IDX_W-1:0]       tag_idx_q [TAG_N];
  logic [IDX_W-1:0]       tag_idx_d [TAG_N];

  logic [NUM_REQ-1:0]     eligible;
  logic [NUM_REQ-1:0]     grant_vec;
  logic                   grant_found;
  logic [IDX_W-1:0]       grant_idx;
  logic [CW-1:0]          cand_w;
  logic [IDX_W-1:0]       cand;
  logic [15:0]            sel_length, sel_width, sel_height;
  logic                   cmp_vld;
  logic [IDX_W-1:0]       cmp_idx;

  // A requester with work in flight or an unconsumed result must not be granted again.
  assign eligible = req_valid & ~outstanding_q & ~rsp_valid_q;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_w      = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_w = {1'b0, rr_ptr_q} + CW'(k);
      if (cand_w >= CW'(NUM_REQ)) begin
        cand_w = cand_w - CW'(NUM_REQ);
      end
      cand = cand_w[IDX_W-1:0];
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_grant
      assign grant_vec[gi] = grant_found && (grant_idx == IDX_W'(gi));
    end
  endgenerate

  // Reset is folded in so req_ready stays low while rst is asserted even with req_valid high.
  assign req_ready = grant_vec & {NUM_REQ{rst}};

  always_comb begin
    sel_length = '0;
    sel_width  = '0;
    sel_height = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_vec[i]) begin
        sel_length = req_length[16*i +: 16];
        sel_width  = req_width[16*i +: 16];
        sel_height = req_height[16*i +: 16];
      end
    end
  end

  assign cmp_vld = tag_vld_q[DP_LAT];
  assign cmp_idx = tag_idx_q[DP_LAT];

  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    outstanding_d = outstanding_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_area_d    = rsp_area_q;
    rsp_volume_d  = rsp_volume_q;
    proto_err_d   = proto_err_q;
    dp_in_valid_d = grant_found;
    dp_length_d   = dp_length_q;
    dp_width_d    = dp_width_q;
    dp_height_d   = dp_height_q;

    if (grant_found) begin
      rr_ptr_d    = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
      dp_length_d = sel_length;
      dp_width_d  = sel_width;
      dp_height_d = sel_height;
    end

    tag_vld_d[0] = grant_found;
    tag_idx_d[0] = grant_idx;
    for (int s = 1; s < TAG_N; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_idx_d[s] = tag_idx_q[s-1];
    end

    // Completion and a new grant always target different requesters, so ordering here is safe.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rsp_valid_q[i] && rsp_ready[i]) begin
        rsp_valid_d[i] = 1'b0;
      end
      if (cmp_vld && (cmp_idx == IDX_W'(i))) begin
        outstanding_d[i] = 1'b0;
        if (dp_out_valid) begin
          rsp_valid_d[i]             = 1'b1;
          rsp_area_d[32*i +: 32]   = dp_area;
          rsp_volume_d[32*i +: 32] = dp_volume;
        end else begin
          proto_err_d = 1'b1;
        end
      end
      if (grant_vec[i]) begin
        outstanding_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q      <= '0;
      outstanding_q <= '0;
      rsp_valid_q   <= '0;
      rsp_area_q    <= '0;
      rsp_volume_q  <= '0;
      proto_err_q   <= 1'b0;
      dp_in_valid_q <= 1'b0;
      dp_length_q   <= '0;
      dp_width_q    <= '0;
      dp_height_q   <= '0;
      tag_vld_q     <= '0;
      for (int s = 0; s < TAG_N; s++) begin
        tag_idx_q[s] <= '0;
      end
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      outstanding_q <= outstanding_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_area_q    <= rsp_area_d;
      rsp_volume_q  <= rsp_volume_d;
      proto_err_q   <= proto_err_d;
      dp_in_valid_q <= dp_in_valid_d;
      dp_length_q   <= dp_length_d;
      dp_width_q    <= dp_width_d;
      dp_height_q   <= dp_height_d;
      tag_vld_q     <= tag_vld_d;
      tag_idx_q     <= tag_idx_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_area    = rsp_area_q;
  assign rsp_volume  = rsp_volume_q;
  assign dp_length   = dp_length_q;
  assign dp_width    = dp_width_q;
  assign dp_height   = dp_height_q;
  assign dp_in_valid = dp_in_valid_q;
  assign proto_err   = proto_err_q;
  assign busy        = (|tag_vld_q) | (|outstanding_q) | (|rsp_valid_q);

endmodule
